// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: FSM state encoding and register widths.
package hazard_ctrl_pkg;
   localparam int REG_W   = 5;   // architectural register index width
   localparam int TIMER_W = 8;   // memory-wait timer width

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_e;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bus: ID/EX hazard inputs and pipeline control outputs.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   import hazard_ctrl_pkg::*;

   logic [REG_W-1:0] ID_rs1, ID_rs2, ID_EX_rd;
   logic             ID_use_rs1, ID_use_rs2, ID_EX_MemRead;
   logic             EX_branch_taken, mem_busy, cnt_clr;
   logic             PC_write, IF_ID_write, ID_EX_write, EX_MEM_write;
   logic             IF_ID_flush, ID_EX_flush, MEM_WB_flush;
   logic             PC_src_branch, halted;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   // pipeline side: drives hazard info, consumes controls
   modport master (
      output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_EX_rd, ID_EX_MemRead,
             EX_branch_taken, mem_busy, cnt_clr,
      input  PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
             IF_ID_flush, ID_EX_flush, MEM_WB_flush, PC_src_branch, halted,
             stall_cnt, flush_cnt
   );

   // hazard controller side
   modport slave (
      input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, ID_EX_rd, ID_EX_MemRead,
             EX_branch_taken, mem_busy, cnt_clr,
      output PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
             IF_ID_flush, ID_EX_flush, MEM_WB_flush, PC_src_branch, halted,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module load_use_detect
   import hazard_ctrl_pkg::*;
(
   input  logic [REG_W-1:0] rs1,
   input  logic [REG_W-1:0] rs2,
   input  logic             use_rs1,
   input  logic             use_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   output logic             hit
);
   // x0 is never a real dependency, so it is excluded up front
   always_comb begin
      hit = ex_mem_read && (ex_rd != '0) &&
            (((ex_rd == rs1) && use_rs1) || ((ex_rd == rs2) && use_rs2));
   end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze/branch/load-use control, memory timeout
// FSM and stall/flush performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W       = 16,   // must match the bus CNT_W
   parameter int MEM_TIMEOUT = 255   // 2..255
) (
   input  logic          clk,
   input  logic          rst,
   hazard_ctrl_if.slave  bus
);
   state_e             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic               lu_hit, stall_ev, flush_ev;

   load_use_detect u_lud (
      .rs1         (bus.ID_rs1),
      .rs2         (bus.ID_rs2),
      .use_rs1     (bus.ID_use_rs1),
      .use_rs2     (bus.ID_use_rs2),
      .ex_rd       (bus.ID_EX_rd),
      .ex_mem_read (bus.ID_EX_MemRead),
      .hit         (lu_hit)
   );

   // Control outputs (freeze > branch > load-use) and FSM/timer next state
   always_comb begin
      bus.PC_write      = 1'b1;
      bus.IF_ID_write   = 1'b1;
      bus.ID_EX_write   = 1'b1;
      bus.EX_MEM_write  = 1'b1;
      bus.IF_ID_flush   = 1'b0;
      bus.ID_EX_flush   = 1'b0;
      bus.MEM_WB_flush  = 1'b0;
      bus.PC_src_branch = 1'b0;
      bus.halted        = 1'b0;
      stall_ev          = 1'b0;
      flush_ev          = 1'b0;
      state_d           = state_q;
      timer_d           = timer_q;

      if (state_q == HALT) begin
         bus.PC_write     = 1'b0;
         bus.IF_ID_write  = 1'b0;
         bus.ID_EX_write  = 1'b0;
         bus.EX_MEM_write = 1'b0;
         bus.halted       = 1'b1;
      end else if (bus.mem_busy) begin
         bus.PC_write     = 1'b0;
         bus.IF_ID_write  = 1'b0;
         bus.ID_EX_write  = 1'b0;
         bus.EX_MEM_write = 1'b0;
         bus.MEM_WB_flush = 1'b1;
         stall_ev         = 1'b1;
      end else if (bus.EX_branch_taken) begin
         // the ID instruction is squashed, so any load-use on it is moot
         bus.PC_src_branch = 1'b1;
         bus.IF_ID_flush   = 1'b1;
         bus.ID_EX_flush   = 1'b1;
         flush_ev          = 1'b1;
      end else if (lu_hit) begin
         bus.PC_write    = 1'b0;
         bus.IF_ID_write = 1'b0;
         bus.ID_EX_flush = 1'b1;
         stall_ev        = 1'b1;
      end

      case (state_q)
         RUN: begin
            if (bus.mem_busy) begin
               state_d = MEM_WAIT;
               timer_d = TIMER_W'(1);
            end
         end
         MEM_WAIT: begin
            if (!bus.mem_busy) begin
               state_d = RUN;
               timer_d = '0;
            end else if (timer_q == TIMER_W'(MEM_TIMEOUT - 1)) begin
               state_d = HALT;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         default: ;   // HALT only leaves through reset
      endcase

      // reset holds the pipeline frozen with every stage bubbled
      if (rst) begin
         bus.PC_write      = 1'b0;
         bus.IF_ID_write   = 1'b0;
         bus.ID_EX_write   = 1'b0;
         bus.EX_MEM_write  = 1'b0;
         bus.IF_ID_flush   = 1'b1;
         bus.ID_EX_flush   = 1'b1;
         bus.MEM_WB_flush  = 1'b1;
         bus.PC_src_branch = 1'b0;
         bus.halted        = 1'b0;
      end
   end

   // Saturating performance counters; clear wins over increment
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_ev && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (flush_ev && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   // State, timer and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         timer_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
endmodule
